// File: rtl/gb_reg_write_decoder.sv
// UART address/data byte stream to validated Game Boy register writes with an 8-deep FWFT write FIFO.
// Define GB_REG_WRITE_CHECKSUM_EN to use 3-byte frames: addr, data, chk = addr ^ data ^ 8'h5A.
module gb_reg_write_decoder #(
  parameter int         DEPTH          = 8,
  parameter int         TIMEOUT_CYCLES = 120,
  parameter logic [7:0] ADDR_LO        = 8'h10,
  parameter logic [7:0] ADDR_HI        = 8'h3F
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_received,
  output logic [15:0]              wr_addr,
  output logic [7:0]               wr_data,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic                     overflow,
  output logic [7:0]               frame_err_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_ADDR = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
`ifdef GB_REG_WRITE_CHECKSUM_EN
  localparam logic [1:0] S_CHK  = 2'd2;
`endif

  logic [1:0]    r_state;
  logic [TW-1:0] r_tmo;
  logic          r_bad;
  logic [7:0]    r_addr;
  logic [7:0]    r_err;
  logic          r_ovf;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [15:0]   r_mem [DEPTH];
`ifdef GB_REG_WRITE_CHECKSUM_EN
  logic [7:0]    r_data;
`endif

  logic          w_tmo_fire;
  logic          w_addr_phase;
  logic          w_fin;
  logic          w_ok;
  logic [7:0]    w_data_byte;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_err;
  logic [15:0]   w_head;

  // A byte that lands on the timeout cycle starts a fresh frame as its address byte.
  always_comb begin
    w_tmo_fire   = (r_state != S_ADDR) && (r_tmo == TW'(TIMEOUT_CYCLES));
    w_addr_phase = rx_received && ((r_state == S_ADDR) || w_tmo_fire);
`ifdef GB_REG_WRITE_CHECKSUM_EN
    w_fin        = rx_received && !w_tmo_fire && (r_state == S_CHK);
    w_ok         = !r_bad && (rx_data == (r_addr ^ r_data ^ 8'h5A));
    w_data_byte  = r_data;
`else
    w_fin        = rx_received && !w_tmo_fire && (r_state == S_DATA);
    w_ok         = !r_bad;
    w_data_byte  = rx_data;
`endif
    w_full       = (r_level == LW'(DEPTH));
    w_empty      = (r_level == '0);
    w_pop        = !w_empty && wr_ready;
    w_push       = w_fin && w_ok && (!w_full || w_pop);
    w_drop       = w_fin && w_ok && w_full && !w_pop;
    w_err        = w_tmo_fire || (w_fin && !w_ok);
    w_head       = r_mem[r_rptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ADDR;
      r_tmo   <= '0;
      r_bad   <= 1'b0;
      r_err   <= '0;
      r_ovf   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_addr_phase) begin
        r_state <= S_DATA;
        r_bad   <= (rx_data < ADDR_LO) || (rx_data > ADDR_HI);
      end else if (w_tmo_fire) begin
        r_state <= S_ADDR;
      end else if (rx_received) begin
`ifdef GB_REG_WRITE_CHECKSUM_EN
        r_state <= (r_state == S_DATA) ? S_CHK : S_ADDR;
`else
        r_state <= S_ADDR;
`endif
      end

      if (rx_received || w_tmo_fire || (r_state == S_ADDR)) r_tmo <= '0;
      else                                                  r_tmo <= r_tmo + TW'(1);

      if (w_err && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
      if (w_drop)                    r_ovf <= 1'b1;

      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
    end
  end

  // Frame bytes and FIFO storage carry no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_addr_phase) r_addr <= rx_data;
`ifdef GB_REG_WRITE_CHECKSUM_EN
    if (rx_received && !w_tmo_fire && (r_state == S_DATA)) r_data <= rx_data;
`endif
    if (w_push) r_mem[r_wptr] <= {r_addr, w_data_byte};
  end

  assign wr_valid        = !w_empty;
  assign wr_addr         = {8'hFF, (w_empty ? 8'h00 : w_head[15:8])};
  assign wr_data         = w_empty ? 8'h00 : w_head[7:0];
  assign overflow        = r_ovf;
  assign frame_err_count = r_err;
  assign fifo_level      = r_level;
endmodule

// File: tb/tb_gb_reg_write_decoder.sv
// Directed bench for gb_reg_write_decoder: vector table of frames plus timeout, overflow and full push+pop sequences.
module tb_gb_reg_write_decoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_received;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        overflow;
  logic [7:0]  frame_err_count;
  logic [3:0]  fifo_level;

  int n_pass = 0;
  int n_total = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic       good;
    logic [7:0] err;
  } vec_t;
  vec_t vec[7];

  gb_reg_write_decoder dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_received(rx_received),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .overflow(overflow), .frame_err_count(frame_err_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_received = 1'b1;
    @(posedge clk);
    #1 rx_received = 1'b0;
  endtask

  // The last byte's strobe cycle drives wr_ready = rdy_last; caller restores it.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic rdy_last);
    send_byte(a);
`ifdef GB_REG_WRITE_CHECKSUM_EN
    send_byte(d);
    @(negedge clk);
    rx_data = a ^ d ^ 8'h5A;
`else
    @(negedge clk);
    rx_data = d;
`endif
    rx_received = 1'b1;
    wr_ready = rdy_last;
    @(posedge clk);
    #1 rx_received = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_ready = 1'b0;
    rx_received = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", wr_valid, 0);
    check("rst_addr", wr_addr, 16'hFF00);
    check("rst_data", wr_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", frame_err_count, 0);
    check("rst_level", fifo_level, 0);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    logic [15:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check("drain_valid", wr_valid, 1);
      check("drain_addr", wr_addr, {8'hFF, e[15:8]});
      check("drain_data", wr_data, e[7:0]);
      wr_ready = 1'b1;
      @(posedge clk);
      #1 wr_ready = 1'b0;
    end
    @(negedge clk);
    check("drain_empty", wr_valid, 0);
    check("drain_level", fifo_level, 0);
  endtask

  initial begin
    vec[0] = '{8'h12, 8'h80, 1'b1, 8'd0};
    vec[1] = '{8'h05, 8'h33, 1'b0, 8'd1};
    vec[2] = '{8'h24, 8'h77, 1'b1, 8'd1};
    vec[3] = '{8'h3F, 8'h01, 1'b1, 8'd1};
    vec[4] = '{8'h10, 8'hFF, 1'b1, 8'd1};
    vec[5] = '{8'h40, 8'h00, 1'b0, 8'd2};
    vec[6] = '{8'h0F, 8'hAA, 1'b0, 8'd3};

    do_reset();

    wr_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_frame(vec[i].a, vec[i].d, 1'b1);
      check("vec_valid", wr_valid, vec[i].good);
      if (vec[i].good) begin
        check("vec_addr", wr_addr, {8'hFF, vec[i].a});
        check("vec_data", wr_data, vec[i].d);
      end
      check("vec_err", frame_err_count, vec[i].err);
      @(posedge clk);
      #1 check("vec_level", fifo_level, 0);
    end

    // Timeout resync: lone address byte, then a long gap.
    send_byte(8'h14);
    repeat (200) @(posedge clk);
    send_frame(8'h20, 8'h11, 1'b1);
    check("tmo_valid", wr_valid, 1);
    check("tmo_addr", wr_addr, 16'hFF20);
    check("tmo_data", wr_data, 8'h11);
    check("tmo_err", frame_err_count, 4);
    @(posedge clk);
    #1;

`ifdef GB_REG_WRITE_CHECKSUM_EN
    send_byte(8'h25); send_byte(8'h77); send_byte(8'h00);
    check("chk_bad_valid", wr_valid, 0);
    check("chk_bad_err", frame_err_count, 5);
    send_byte(8'h25); send_byte(8'h77); send_byte(8'h08);
    check("chk_good_valid", wr_valid, 1);
    check("chk_good_addr", wr_addr, 16'hFF25);
    check("chk_good_data", wr_data, 8'h77);
    @(posedge clk);
    #1;
`endif

    // Overflow: nine frames into a stalled FIFO.
    wr_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send_frame(8'h10 + 8'(i), 8'hA0 + 8'(i), 1'b0);
      if (i < 8) exp_q.push_back({8'h10 + 8'(i), 8'hA0 + 8'(i)});
      if (i == 7) begin
        check("ovf_pre_level", fifo_level, 8);
        check("ovf_pre_flag", overflow, 0);
      end
    end
    check("ovf_level", fifo_level, 8);
    check("ovf_flag", overflow, 1);
`ifdef GB_REG_WRITE_CHECKSUM_EN
    check("ovf_err", frame_err_count, 5);
`else
    check("ovf_err", frame_err_count, 4);
`endif
    drain(8);
    check("ovf_sticky", overflow, 1);

    // Reset mid-frame with data in the FIFO.
    send_frame(8'h11, 8'h22, 1'b0);
    send_byte(8'h30);
    check("mid_level", fifo_level, 1);
    do_reset();

    // Full FIFO with a pop on the completing edge.
    for (int i = 0; i < 8; i++) begin
      send_frame(8'h20 + 8'(i), 8'h50 + 8'(i), 1'b0);
      exp_q.push_back({8'h20 + 8'(i), 8'h50 + 8'(i)});
    end
    check("pp_full_level", fifo_level, 8);
    send_frame(8'h3A, 8'hC3, 1'b1);
    wr_ready = 1'b0;
    check("pp_level", fifo_level, 8);
    check("pp_ovf", overflow, 0);
    check("pp_err", frame_err_count, 0);
    void'(exp_q.pop_front());
    exp_q.push_back(16'h3AC3);
    drain(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
